// File: rtl/sdram_wr_burst.sv
// rtl/sdram_wr_burst.sv - write-path burst drain stage between the write FIFO and the SDRAM controller
module sdram_wr_burst #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           CNT_WIDTH  = 10,
  parameter int unsigned           ADDR_WIDTH = 24,
  parameter int unsigned           BURST_LEN  = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  init_done,
  input  logic                  flush,
  input  logic [CNT_WIDTH-1:0]  fifo_use_num,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_req,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_len,
  input  logic                  wr_data_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] BURST_CNT  = CNT_WIDTH'(BURST_LEN);
  localparam logic [7:0]           BURST_LEN8 = 8'(BURST_LEN);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]              wr_len_q, wr_len_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    err_q, err_d;

  logic                    trigger;
  logic                    beat;
  logic                    last_beat;
  logic [7:0]              fill_len;
  logic [ADDR_WIDTH:0]     addr_next;

  // Burst trigger, burst length to latch, beat qualification and next-burst address.
  always_comb begin
    fill_len = (fifo_use_num >= BURST_CNT) ? BURST_LEN8 : 8'(fifo_use_num);
    // A non-empty FIFO reporting a zero count would otherwise latch an endless zero-length burst.
    if (fill_len == 8'd0) begin
      fill_len = 8'd1;
    end
    trigger   = init_done && ((fifo_use_num >= BURST_CNT) || (flush_pend_q && !fifo_empty));
    beat      = (state_q == ST_BURST) && wr_data_req && (beat_cnt_q < wr_len_q);
    last_beat = beat && ((beat_cnt_q + 8'd1) == wr_len_q);
    addr_next = {1'b0, wr_addr_q} + (ADDR_WIDTH + 1)'(wr_len_q);
  end

  // State and datapath registers; clr abandons any burst in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= ADDR_BASE;
      wr_len_q     <= 8'd0;
      beat_cnt_q   <= 8'd0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_len_q     <= wr_len_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: IDLE -> REQ -> BURST -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trigger)   state_d = ST_REQ;
      ST_REQ:   if (wr_ack)    state_d = ST_BURST;
      ST_BURST: if (last_beat) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: length latch, beat counting, underflow, flush capture, address advance.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    wr_len_d     = wr_len_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    // A flush arriving in the same cycle as the empty-IDLE clear keeps the request pending.
    if (flush) begin
      flush_pend_d = 1'b1;
    end else if ((state_q == ST_IDLE) && fifo_empty) begin
      flush_pend_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (trigger) wr_len_d = fill_len;
      end
      ST_REQ: begin
        if (wr_ack) beat_cnt_d = 8'd0;
      end
      ST_BURST: begin
        // Underflowed beats still count so the controller's burst always terminates.
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (fifo_empty) err_d = 1'b1;
        end
      end
      ST_DONE: begin
        wr_addr_d = (addr_next > {1'b0, ADDR_MAX}) ? ADDR_BASE : addr_next[ADDR_WIDTH-1:0];
      end
      default: begin
        beat_cnt_d = beat_cnt_q;
      end
    endcase
  end

  // Outputs decoded from state; the FIFO pop and write data are combinational per beat.
  always_comb begin
    wr_req      = (state_q == ST_REQ);
    wr_done     = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    fifo_rd_req = beat && !fifo_empty;
    wr_data     = fifo_rd_req ? fifo_rd_data : '0;
  end

  assign wr_addr       = wr_addr_q;
  assign wr_len        = wr_len_q;
  assign err_underflow = err_q;

endmodule
